// File: rtl/circuito_pkg.sv
// Shared constants and helpers for the circuito_or LED block.
// Debounce is built only when CIRCUITO_DEBOUNCE_EN is defined.
package circuito_pkg;

  localparam int   SYNC_STAGES = 2;
  localparam logic LED_ON      = 1'b1;
  localparam logic LED_OFF     = 1'b0;
  localparam logic BTN_PRESSED = 1'b1;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/circuito_debounce.sv
// Per-button synchroniser with optional debounce filter.
// Filter logic present only when CIRCUITO_DEBOUNCE_EN is defined.
module circuito_debounce
  import circuito_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_btn
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65536) begin : g_bad
    $error("DEBOUNCE_CYCLES out of range");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef CIRCUITO_DEBOUNCE_EN
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LP_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_state;

  // Accept the new level on the D-th consecutive differing cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_state <= 1'b0;
    end else if (w_sync != r_state) begin
      if (r_cnt == LP_LAST) begin
        r_cnt   <= '0;
        r_state <= w_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_btn = r_state;
`else
  assign o_btn = w_sync;
`endif

endmodule

// File: rtl/circuito_or.sv
// Two-button OR driving a registered LED output.
// Define CIRCUITO_DEBOUNCE_EN to filter button bounce.
module circuito_or
  import circuito_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pino2,
  input  logic pino3,
  output logic pino13
);

  logic w_btn2;
  logic w_btn3;
  logic r_led;

  circuito_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db2 (
    .clk  (clk),
    .rst_n(rst_n),
    .i_btn(pino2),
    .o_btn(w_btn2)
  );

  circuito_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db3 (
    .clk  (clk),
    .rst_n(rst_n),
    .i_btn(pino3),
    .o_btn(w_btn3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= LED_OFF;
    end else if (w_btn2 == BTN_PRESSED ||
                 w_btn3 == BTN_PRESSED) begin
      r_led <= LED_ON;
    end else begin
      r_led <= LED_OFF;
    end
  end

  assign pino13 = r_led;

endmodule

// File: tb/tb_circuito_or.sv
// Randomised scoreboard bench for circuito_or.
// Honours CIRCUITO_DEBOUNCE_EN for the expected latency.
module tb_circuito_or;

  localparam int D = 4;
`ifdef CIRCUITO_DEBOUNCE_EN
  localparam int LAT  = 3 + D;
  localparam int PIPE = 3;
  localparam bit DB   = 1'b1;
`else
  localparam int LAT  = 3;
  localparam int PIPE = 2;
  localparam bit DB   = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pino2 = 1'b0;
  logic pino3 = 1'b0;
  logic pino13;

  int checks = 0;
  int errors = 0;

  circuito_or #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pino2 (pino2),
    .pino3 (pino3),
    .pino13(pino13)
  );

  always #5 clk = ~clk;

  // Reference: a button's settled level flips once the last D
  // samples all show the opposite level.
  bit    exp_q[$];
  bit    filt[2];
  bit    hist2[$];
  bit    hist3[$];

  function automatic bit settle(input bit s, input bit f,
                                inout bit h[$]);
    bit all_opp;
    if (!DB) return s;
    h.push_back(s);
    if (h.size() > D) void'(h.pop_front());
    all_opp = (h.size() == D);
    foreach (h[i]) if (h[i] == f) all_opp = 1'b0;
    if (all_opp) begin
      h.delete();
      return ~f;
    end
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      hist2.delete();
      hist3.delete();
      filt[0] = 1'b0;
      filt[1] = 1'b0;
      for (int i = 0; i < PIPE; i++) exp_q.push_back(1'b0);
    end else begin
      filt[0] = settle(pino2, filt[0], hist2);
      filt[1] = settle(pino3, filt[1], hist3);
      exp_q.push_back(filt[0] | filt[1]);
    end
  end

  always @(negedge clk) begin
    bit e;
    if (rst_n) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (pino13 !== e) begin
          errors++;
          $display("FAIL led t=%0t got=%b exp=%b", $time, pino13, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic drive(input bit b2, input bit b3, input int cyc);
    @(negedge clk);
    pino2 = b2;
    pino3 = b3;
    repeat (cyc - 1) @(negedge clk);
  endtask

  // Edges from the first sampling edge until pino13 goes high.
  task automatic latency(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (pino13 === 1'b1) break;
    end
  endtask

  int n;

  initial begin
    pino2 = 1'b1;
    pino3 = 1'b1;
    #1;
    chk("reset_led", int'(pino13), 0);
    #12;
    chk("reset_led_clocked", int'(pino13), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    latency(n);
    chk("release_latency", n, LAT);

    drive(0, 0, 2 * LAT + 10);
    drive(1, 0, LAT + 10);
    drive(0, 0, LAT + 10);
    drive(0, 1, LAT + 10);
    drive(1, 1, LAT + 10);
    drive(0, 1, LAT + 10);
    drive(0, 0, LAT + 10);

    drive(1, 0, 3);
    drive(0, 0, LAT + 10);

    @(negedge clk);
    pino2 = 1'b1;
    latency(n);
    chk("hold_latency", n, LAT);
    drive(0, 0, LAT + 10);

    @(negedge clk);
    pino3 = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_led", int'(pino13), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    latency(n);
    chk("midreset_latency", n, LAT);
    drive(0, 0, LAT + 10);

    @(negedge clk);
    #4 pino2 = 1'b1;
    latency(n);
    checks++;
    if (n != LAT && n != LAT + 1) begin
      errors++;
      $display("FAIL async_latency got=%0d exp=%0d", n, LAT);
    end
    drive(0, 0, LAT + 10);

    for (int i = 0; i < 150; i++) begin
      drive(1'($urandom), 1'($urandom),
            int'($urandom_range(1, 2 * D + 2)));
    end
    drive(0, 0, LAT + 10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
